// File: rtl/hsv2rgb.sv
// hsv2rgb: 4-stage pipelined HSV -> RGB converter behind a global-stall valid/ready interface.
// Define HSV2RGB_HUE_WRAP_EN to fold hues in [360,720) degrees back by one turn.
module hsv2rgb #(
   parameter int unsigned FIXED = 4,
   parameter int unsigned WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] h,
   input  logic [7:0]       s,
   input  logic [7:0]       v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b
);

   // Remainder within a 60 degree sector always fits in FIXED+6 bits.
   localparam int unsigned RW = FIXED + 6;
   localparam int unsigned MW = RW + 5;

   localparam logic [WIDTH-1:0] H60  = WIDTH'(60 << FIXED);
   localparam logic [WIDTH-1:0] H120 = WIDTH'(120 << FIXED);
   localparam logic [WIDTH-1:0] H180 = WIDTH'(180 << FIXED);
   localparam logic [WIDTH-1:0] H240 = WIDTH'(240 << FIXED);
   localparam logic [WIDTH-1:0] H300 = WIDTH'(300 << FIXED);
   localparam logic [WIDTH-1:0] H360 = WIDTH'(360 << FIXED);
`ifdef HSV2RGB_HUE_WRAP_EN
   localparam logic [WIDTH-1:0] H720 = WIDTH'(720 << FIXED);
`endif

   // Floor division by 255, exact for x <= 255*255.
   function automatic logic [7:0] div255(input logic [15:0] x);
      return 8'(({1'b0, x} + 17'd1 + {9'd0, x[15:8]}) >> 8);
   endfunction

   logic en;

   // Stage registers
   logic          s1_valid, s2_valid, s3_valid;
   logic [2:0]    s1_sector, s2_sector, s3_sector;
   logic [RW-1:0] s1_rem;
   logic [7:0]    s1_s, s1_v;
   logic [7:0]    s2_f8, s2_s, s2_v;
   logic [15:0]   s2_pv;
   logic [7:0]    s3_p, s3_sf, s3_sg, s3_v;

   // Next-state values
   logic [WIDTH-1:0] h_fix;
   logic [WIDTH-1:0] h_off;
   logic [2:0]       sector;
   logic [RW-1:0]    rem;
   logic [MW-1:0]    rem17;
   logic [7:0]       f8;
   logic [15:0]      pv;
   logic [7:0]       p, sf, sg;
   logic [7:0]       q, t;
   logic [7:0]       r_d, g_d, b_d;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // S1: hue range fix and sector split
   always_comb begin
      h_fix = h;
`ifdef HSV2RGB_HUE_WRAP_EN
      if (h >= H720) begin
         h_fix = '0;
      end else if (h >= H360) begin
         h_fix = h - H360;
      end
`else
      if (h >= H360) begin
         h_fix = '0;
      end
`endif
      if (h_fix >= H300) begin
         sector = 3'd5;
         h_off  = H300;
      end else if (h_fix >= H240) begin
         sector = 3'd4;
         h_off  = H240;
      end else if (h_fix >= H180) begin
         sector = 3'd3;
         h_off  = H180;
      end else if (h_fix >= H120) begin
         sector = 3'd2;
         h_off  = H120;
      end else if (h_fix >= H60) begin
         sector = 3'd1;
         h_off  = H60;
      end else begin
         sector = 3'd0;
         h_off  = '0;
      end
      rem = RW'(h_fix - h_off);
   end

   // S2: 8-bit fraction within the sector, and v*(255-s)
   always_comb begin
      rem17 = MW'(s1_rem) * MW'(17);
      f8    = 8'(rem17 >> (FIXED + 2));
      pv    = 16'(s1_v) * 16'(8'd255 - s1_s);
   end

   // S3
   always_comb begin
      p  = div255(s2_pv);
      sf = div255(16'(s2_s) * 16'(s2_f8));
      sg = div255(16'(s2_s) * 16'(8'd255 - s2_f8));
   end

   // S4: falling/rising ramps and sector mux
   always_comb begin
      q   = div255(16'(s3_v) * 16'(8'd255 - s3_sf));
      t   = div255(16'(s3_v) * 16'(8'd255 - s3_sg));
      r_d = '0;
      g_d = '0;
      b_d = '0;
      case (s3_sector)
         3'd0: begin r_d = s3_v; g_d = t;    b_d = s3_p; end
         3'd1: begin r_d = q;    g_d = s3_v; b_d = s3_p; end
         3'd2: begin r_d = s3_p; g_d = s3_v; b_d = t;    end
         3'd3: begin r_d = s3_p; g_d = q;    b_d = s3_v; end
         3'd4: begin r_d = t;    g_d = s3_p; b_d = s3_v; end
         3'd5: begin r_d = s3_v; g_d = s3_p; b_d = q;    end
         default: begin r_d = '0; g_d = '0; b_d = '0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid  <= 1'b0;
         s1_sector <= '0;
         s1_rem    <= '0;
         s1_s      <= '0;
         s1_v      <= '0;
         s2_valid  <= 1'b0;
         s2_sector <= '0;
         s2_f8     <= '0;
         s2_s      <= '0;
         s2_v      <= '0;
         s2_pv     <= '0;
         s3_valid  <= 1'b0;
         s3_sector <= '0;
         s3_p      <= '0;
         s3_sf     <= '0;
         s3_sg     <= '0;
         s3_v      <= '0;
         out_valid <= 1'b0;
         r         <= '0;
         g         <= '0;
         b         <= '0;
      end else if (en) begin
         s1_valid  <= in_valid;
         s1_sector <= sector;
         s1_rem    <= rem;
         s1_s      <= s;
         s1_v      <= v;
         s2_valid  <= s1_valid;
         s2_sector <= s1_sector;
         s2_f8     <= f8;
         s2_s      <= s1_s;
         s2_v      <= s1_v;
         s2_pv     <= pv;
         s3_valid  <= s2_valid;
         s3_sector <= s2_sector;
         s3_p      <= p;
         s3_sf     <= sf;
         s3_sg     <= sg;
         s3_v      <= s2_v;
         out_valid <= s3_valid;
         r         <= r_d;
         g         <= g_d;
         b         <= b_d;
      end
   end

endmodule
